// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU operation scheduler.
package alu_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Function classes decoded by the ALU from FUNC[3:2]; the scheduler passes FUNC through untouched.
  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  // Requester identifier width (two clients).
  localparam int ID_W = 1;

  // Cycles allowed in WAIT before an error response is returned.
  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module alu_rr_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer update: after a grant the pointer favours the other requester.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch inferred).
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    if (advance && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  // Pointer register, synchronously reset to favour requester 0.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters: arbitrate, issue, wait with timeout, respond.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [3:0]       REQ0_FUNC,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [3:0]       REQ1_FUNC,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUNC,
  output logic             ALU_EN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_OUT_VALID,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [ID_W-1:0]  RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_ERR,
  output logic             BUSY
);

  // Last counter value seen in WAIT before the timeout fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_func_q, alu_func_d;
  logic             alu_en_q, alu_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

  logic             can_accept;
  logic [1:0]       arb_req;
  logic [1:0]       gnt;

  // Requests are only offered to the arbiter while idle and out of reset.
  assign can_accept = (state_q == IDLE) && !RST;
  assign arb_req    = {REQ1_VALID, REQ0_VALID} & {2{can_accept}};

  alu_rr_arbiter u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (arb_req),
    .advance (can_accept),
    .gnt     (gnt)
  );

  assign REQ0_READY = gnt[0];
  assign REQ1_READY = gnt[1];

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    alu_en_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          alu_a_d    = gnt[1] ? REQ1_A    : REQ0_A;
          alu_b_d    = gnt[1] ? REQ1_B    : REQ0_B;
          alu_func_d = gnt[1] ? REQ1_FUNC : REQ0_FUNC;
          rsp_id_d   = gnt[1];
          alu_en_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ALU_OUT_VALID) begin
          rsp_data_d  = ALU_OUT;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any in-flight op or pending response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= 4'd0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUNC  = alu_func_q;
  assign ALU_EN    = alu_en_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign BUSY      = busy_q;

endmodule
